// File: rtl/program_loader.sv
// program_loader: parses an A5/length/words byte frame into instruction-memory writes, then releases the CPU.
// Build option: define LOADER_CHECKSUM_EN to require a trailing XOR check byte (adds the CHECK state).
module program_loader (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady,
  output logic [10:0] ImemAddr,
  output logic [15:0] ImemData,
  output logic        ImemWe,
  output logic        CpuReset,
  output logic        Done,
  output logic        Error,
  output logic [2:0]  DbgState
);

  // Byte handshake: a byte moves on a rising edge only when RxValid && RxReady; otherwise it has no effect.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DAT_HI = 3'd3,
    S_DAT_LO = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK  = 3'd5,
`endif
    S_RUN    = 3'd6,
    S_ERROR  = 3'd7
  } state_e;

  localparam logic [7:0]  HEADER  = 8'hA5;
  localparam logic [15:0] MAX_LEN = 16'd2048;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [11:0] idx_q, idx_d;
  logic [15:0] data_q, data_d;
  logic        we_q, we_d;
  logic        rx_ready_q;
  logic        cpu_reset_q;
  logic        done_q;
  logic        error_q;

  logic        accept;
  logic [15:0] len_full;
  logic        len_ok;
  logic        last_word;

  assign accept    = RxValid && rx_ready_q;
  assign len_full  = {len_q[15:8], RxData};
  assign len_ok    = (len_full != 16'd0) && (len_full <= MAX_LEN);
  // The index has already advanced past the previous word's strobe when the next low byte lands.
  assign last_word = ({4'd0, idx_q} == (len_q - 16'd1));

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (accept) begin
      if (((state_q == S_IDLE) || (state_q == S_ERROR)) && (RxData == HEADER)) begin
        csum_d = 8'h00;
      end else if ((state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                   (state_q == S_DAT_HI) || (state_q == S_DAT_LO)) begin
        csum_d = csum_q ^ RxData;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = we_q ? (idx_q + 12'd1) : idx_q;
    data_d  = data_q;
    we_d    = 1'b0;
    if (accept) begin
      unique case (state_q)
        S_IDLE, S_ERROR: begin
          if (RxData == HEADER) begin
            state_d = S_LEN_HI;
            idx_d   = 12'd0;
          end
        end
        S_LEN_HI: begin
          len_d   = {RxData, len_q[7:0]};
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d   = len_full;
          state_d = len_ok ? S_DAT_HI : S_ERROR;
        end
        S_DAT_HI: begin
          data_d[15:8] = RxData;
          state_d      = S_DAT_LO;
        end
        S_DAT_LO: begin
          data_d[7:0] = RxData;
          we_d        = 1'b1;
          if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_RUN;
`endif
          end else begin
            state_d = S_DAT_HI;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          state_d = (RxData == csum_q) ? S_RUN : S_ERROR;
        end
`endif
        default: ;
      endcase
    end
  end

  // Status outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      len_q       <= 16'd0;
      idx_q       <= 12'd0;
      data_q      <= 16'd0;
      we_q        <= 1'b0;
      rx_ready_q  <= 1'b1;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      we_q        <= we_d;
      rx_ready_q  <= (state_d != S_RUN);
      cpu_reset_q <= (state_d != S_RUN);
      done_q      <= (state_d == S_RUN);
      error_q     <= (state_d == S_ERROR);
    end
  end

  assign RxReady  = rx_ready_q;
  assign ImemAddr = idx_q[10:0];
  assign ImemData = data_q;
  assign ImemWe   = we_q;
  assign CpuReset = cpu_reset_q;
  assign Done     = done_q;
  assign Error    = error_q;
  assign DbgState = state_q;

  a_we_single: assert property (@(posedge Clock) disable iff (Reset) ImemWe |=> !ImemWe);
  a_run_quiet: assert property (@(posedge Clock) disable iff (Reset) Done |-> (!RxReady && !CpuReset && !Error));

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table vectors, hand sequences for reset/length corners, random gapped frames vs a frame-parsing model.
module tb_program_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif
  localparam int W = 27;
  localparam logic [7:0] HDR = 8'hA5;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [7:0]  RxData;
  logic        RxValid;
  logic        RxReady;
  logic [10:0] ImemAddr;
  logic [15:0] ImemData;
  logic        ImemWe;
  logic        CpuReset;
  logic        Done;
  logic        Error;
  logic [2:0]  DbgState;

  always #5 Clock = ~Clock;

  program_loader dut (
    .Clock(Clock), .Reset(Reset), .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady),
    .ImemAddr(ImemAddr), .ImemData(ImemData), .ImemWe(ImemWe), .CpuReset(CpuReset),
    .Done(Done), .Error(Error), .DbgState(DbgState)
  );

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [7:0]   sq[$];
  bit exp_done, exp_err;

  typedef struct {
    bit           rst;
    int           n;
    logic [127:0] raw;
    bit           done;
    bit           err;
    int           writes;
  } vec_t;
  vec_t vecs[7];

  // Every strobe cycle is captured; a stretched pulse shows up as an extra entry.
  always @(negedge Clock) if (ImemWe) got_q.push_back({ImemAddr, ImemData});

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(bit rst, int n, logic [127:0] val, bit has_ck, logic [7:0] ck,
                              bit d, bit e, int wr);
    vec_t v;
    logic [127:0] x;
    int m;
    x = val;
    m = n;
    if (has_ck && CK_EN) begin
      x = {x[119:0], ck};
      m = n + 1;
    end
    v.rst = rst; v.n = m; v.raw = x << (8 * (16 - m));
    v.done = d; v.err = e; v.writes = wr;
    return v;
  endfunction

  // Frame parser over the whole byte list: header hunt, length, word pairs, optional check byte.
  task automatic model(input logic [7:0] s[$]);
    int p, len, w;
    logic [7:0] cs;
    p = 0;
    while (p < s.size() && !exp_done) begin
      if (s[p] != HDR) begin p++; continue; end
      p++;
      exp_err = 1'b0;
      if (p + 1 >= s.size()) break;
      len = int'({s[p], s[p+1]});
      cs = s[p] ^ s[p+1];
      p += 2;
      if (len == 0 || len > 2048) begin exp_err = 1'b1; continue; end
      for (w = 0; w < len && p + 1 < s.size(); w++) begin
        exp_q.push_back({w[10:0], s[p], s[p+1]});
        cs = cs ^ s[p] ^ s[p+1];
        p += 2;
      end
      if (w < len) break;
      if (CK_EN) begin
        if (p >= s.size()) break;
        exp_done = (s[p] == cs);
        exp_err = !exp_done;
        p++;
      end else begin
        exp_done = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1; RxValid = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    exp_done = 1'b0; exp_err = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n, k;
    if (gaps) begin
      n = $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) n = 40;
      repeat (n) begin
        RxValid = 1'b0; RxData = 8'($urandom);
        @(negedge Clock);
      end
    end
    RxData = b; RxValid = 1'b1;
    k = 0;
    while (!RxReady && k < 100) begin @(negedge Clock); k++; end
    if (k == 100) begin
      checks++; failures++;
      $display("FAIL rx_ready_timeout got=0 expected=1");
    end else begin
      @(negedge Clock);
    end
    RxValid = 1'b0;
  endtask

  task automatic drain(input string name);
    logic [W-1:0] g, e;
    while (exp_q.size() > 0 || got_q.size() > 0) begin
      g = (got_q.size() > 0) ? got_q.pop_front() : '1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      chk({name, ".write"}, 32'(g), 32'(e));
    end
  endtask

  task automatic final_status(input string name);
    chk({name, ".done"}, 32'(Done), 32'(exp_done));
    chk({name, ".error"}, 32'(Error), 32'(exp_err));
    chk({name, ".cpu_reset"}, 32'(CpuReset), 32'(!exp_done));
    chk({name, ".rx_ready"}, 32'(RxReady), 32'(!exp_done));
  endtask

  task automatic run_stream(input string name, input bit gaps);
    model(sq);
    foreach (sq[k]) send_byte(sq[k], gaps);
    repeat (3) @(negedge Clock);
    drain(name);
    final_status(name);
  endtask

  task automatic poke_run();
    for (int k = 0; k < 6; k++) begin
      RxValid = 1'b1;
      RxData = (k == 0) ? HDR : 8'($urandom);
      @(negedge Clock);
    end
    RxValid = 1'b0;
    repeat (2) @(negedge Clock);
    chk("run.no_write", 32'(got_q.size()), 32'd0);
    chk("run.done_hold", 32'(Done), 32'd1);
    chk("run.cpu_reset", 32'(CpuReset), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, ".addr"}, 32'(ImemAddr), 32'd0);
    chk({name, ".data"}, 32'(ImemData), 32'd0);
    chk({name, ".we"}, 32'(ImemWe), 32'd0);
    chk({name, ".cpu_reset"}, 32'(CpuReset), 32'd1);
    chk({name, ".done"}, 32'(Done), 32'd0);
    chk({name, ".error"}, 32'(Error), 32'd0);
    chk({name, ".rx_ready"}, 32'(RxReady), 32'd1);
  endtask

  task automatic add_frame(input int len, input bit corrupt);
    logic [7:0] cs, hi, lo;
    logic [15:0] l16;
    l16 = 16'(len);
    sq.push_back(HDR);
    sq.push_back(l16[15:8]);
    sq.push_back(l16[7:0]);
    cs = l16[15:8] ^ l16[7:0];
    if (len == 0 || len > 2048) return;
    for (int i = 0; i < len; i++) begin
      hi = 8'($urandom); lo = 8'($urandom);
      sq.push_back(hi); sq.push_back(lo);
      cs = cs ^ hi ^ lo;
    end
    if (CK_EN) sq.push_back(corrupt ? (cs ^ (8'h01 << $urandom_range(0, 7))) : cs);
  endtask

  initial begin
    Reset = 1'b1; RxValid = 1'b0; RxData = 8'h00;
    exp_done = 1'b0; exp_err = 1'b0;

    vecs[0] = mk(1'b1, 7, 128'hA500021234ABCD, 1'b1, 8'h42, 1'b1, 1'b0, 2);
    vecs[1] = mk(1'b1, 5, 128'h00FFA50000,     1'b0, 8'h00, 1'b0, 1'b1, 0);
    vecs[2] = mk(1'b0, 5, 128'hA500010007,     1'b1, 8'h06, 1'b1, 1'b0, 1);
    vecs[3] = mk(1'b1, 3, 128'hA50801,         1'b0, 8'h00, 1'b0, 1'b1, 0);
    vecs[4] = mk(1'b1, 5, 128'hA500011234,     1'b1, 8'hFF, !CK_EN, CK_EN, 1);
    vecs[5] = mk(1'b1, 5, 128'hA5000155AA,     1'b1, 8'hFE, 1'b1, 1'b0, 1);
    vecs[6] = mk(1'b1, 3, 128'h001122,         1'b0, 8'h00, 1'b0, 1'b0, 0);

    repeat (2) @(negedge Clock);
    chk_reset_outputs("reset");
    Reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst) do_reset();
      sq.delete();
      for (int k = 0; k < vecs[i].n; k++) sq.push_back(vecs[i].raw[127 - 8*k -: 8]);
      model(sq);
      foreach (sq[k]) send_byte(sq[k], 1'b0);
      repeat (3) @(negedge Clock);
      chk($sformatf("vec%0d.writes", i), 32'(got_q.size()), 32'(vecs[i].writes));
      chk($sformatf("vec%0d.done", i), 32'(Done), 32'(vecs[i].done));
      chk($sformatf("vec%0d.error", i), 32'(Error), 32'(vecs[i].err));
      drain($sformatf("vec%0d", i));
      final_status($sformatf("vec%0d.model", i));
      if (vecs[i].done) poke_run();
    end

    // Reset while word 3 is half-received, then a clean frame from address 0.
    do_reset();
    sq.delete();
    sq = '{8'hA5, 8'h00, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    model(sq);
    foreach (sq[k]) send_byte(sq[k], 1'b0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    chk_reset_outputs("midreset");
    Reset = 1'b0;
    exp_done = 1'b0; exp_err = 1'b0;
    drain("midreset.pre");
    sq.delete();
    add_frame(3, 1'b0);
    run_stream("midreset.post", 1'b0);

    // Reset arriving with the low byte: the strobe must never appear.
    do_reset();
    sq.delete();
    sq = '{8'hA5, 8'h00, 8'h02, 8'h12};
    model(sq);
    foreach (sq[k]) send_byte(sq[k], 1'b0);
    RxData = 8'h34; RxValid = 1'b1; Reset = 1'b1;
    @(negedge Clock);
    chk("cancel.we", 32'(ImemWe), 32'd0);
    chk("cancel.data", 32'(ImemData), 32'd0);
    Reset = 1'b0; RxValid = 1'b0;
    exp_done = 1'b0; exp_err = 1'b0;
    repeat (2) @(negedge Clock);
    drain("cancel");

    // Maximum length fills the whole memory.
    do_reset();
    sq.delete();
    add_frame(2048, 1'b0);
    run_stream("maxlen", 1'b0);

    // Random frames with gaps, junk, bad lengths and corrupted check bytes.
    for (int it = 0; it < 25; it++) begin
      do_reset();
      sq.delete();
      repeat ($urandom_range(0, 3)) sq.push_back(8'($urandom_range(0, 164)));
      if ($urandom_range(0, 5) == 0) begin
        add_frame(($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(2049, 65535)), 1'b0);
        repeat ($urandom_range(0, 2)) sq.push_back(8'($urandom_range(0, 164)));
      end
      add_frame(int'($urandom_range(1, 6)), ($urandom_range(0, 3) == 0));
      run_stream($sformatf("rand%0d", it), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
